strobe_period_monitor: RTL
==========================

Name: strobe_period_monitor

Overview:
- Consumes a periodic single-cycle strobe, such as one from the design's static strobe generators, and measures the clock count between consecutive strobe events.
- Checks each measured period against an expected rate and tolerance.
- Reports lock, and flags a timeout when strobes stop arriving.
- Used as an on-chip self-check on game-tick and display-refresh strobes.

Parameters:
- EXPECTED_FREQ_HZ, 1, expected strobe rate. EXP_PERIOD = `BOARD_CLK_MHZ*1_000_000/EXPECTED_FREQ_HZ + 1 clock cycles between events.
- TOL_CYCLES, 2, allowed absolute deviation |period - EXP_PERIOD|, inclusive.
- LOCK_COUNT, 4, number of consecutive in-tolerance periods needed to assert lock (>=1).
- TIMEOUT_CYCLES, 2*EXP_PERIOD, gap without an event that declares timeout.
- Derived: CNT_W = $clog2(TIMEOUT_CYCLES+1); LCK_W = $clog2(LOCK_COUNT+1).

Ports:
- clk_i, input, 1, system clock.
- rst_i, input, 1, synchronous active-high reset.
- strobe_i, input, 1, monitored strobe; an event is a rising edge.
- clear_i, input, 1, synchronous soft clear with the same effect as rst_i.
- period_o, output, CNT_W, last measured period in cycles.
- period_valid_o, output, 1, one-cycle pulse when period_o updates.
- in_tol_o, output, 1, tolerance result for the last period; valid with and after period_valid_o.
- lock_o, output, 1, high after LOCK_COUNT consecutive in-tolerance periods.
- timeout_o, output, 1, high while in TIMEOUT.

Behaviour:
- Edge detect:
  - strobe_q is the registered strobe_i; reset value 0.
  - event = strobe_i & ~strobe_q. A strobe held high for N cycles counts as one event.
- Reset / clear:
  - state = IDLE; cnt = 0; period_o = 0; period_valid_o = 0; in_tol_o = 0; lock_o = 0; timeout_o = 0; streak = 0; strobe_q = 0.
  - clear_i has priority over a same-cycle event; that event is discarded.
- State IDLE (no reference point yet):
  - On event: cnt <= 1, go to MEASURE. No period is reported.
  - cnt holds at 0 and timeout is not evaluated.
- State MEASURE:
  - On event:
    - period_o <= cnt; period_valid_o <= 1 on the next cycle, for exactly one cycle.
    - in_tol_o <= (|cnt - EXP_PERIOD| <= TOL_CYCLES).
    - cnt <= 1.
  - Without event: cnt <= cnt + 1.
  - If cnt == TIMEOUT_CYCLES with no event that cycle: go to TIMEOUT, set timeout_o <= 1, lock_o <= 0, streak <= 0, cnt holds.
  - An event arriving on exactly the cycle cnt == TIMEOUT_CYCLES is measured normally (period = TIMEOUT_CYCLES); no timeout.
- State TIMEOUT:
  - cnt saturates and no period is reported.
  - On event: timeout_o <= 0, cnt <= 1, go to MEASURE. The gap is not reported as a period.
- Lock logic, updated with each measured period:
  - In tolerance: streak <= min(streak+1, LOCK_COUNT); lock_o <= 1 once streak reaches LOCK_COUNT.
  - Out of tolerance: streak <= 0, lock_o <= 0 in the same update.
- Latency: period_o, in_tol_o, lock_o and period_valid_o change 1 cycle after the cycle in which strobe_i rises.
- Widths: all comparisons are unsigned. The deviation is computed as the larger minus the smaller operand, so it never underflows.

Optional Feature:
- Macro: STROBE_MON_STATS_EN.
- Defined:
  - Adds outputs min_period_o[CNT_W] and max_period_o[CNT_W].
  - Reset/clear values: min = all ones, max = 0.
  - Both update on every measured period, in the same cycle as period_o.
  - TIMEOUT gaps are excluded.
- Not defined: these ports and registers are absent. All other behaviour is identical.

Test Plan:
- BOARD_CLK_MHZ=50, EXPECTED_FREQ_HZ=1_000_000 (EXP_PERIOD=51), strobe every 51 cycles, 6 strobes:
  - -> 5 period_valid_o pulses, each with period_o = 51 and in_tol_o = 1.
  - -> lock_o rises on the 4th pulse and stays 1.
- Locked, then one gap of 55 cycles (TOL_CYCLES=2) -> period_o = 55, in_tol_o = 0, lock_o drops the same cycle. The 4 following 51-cycle periods relock.
- Locked, then strobe stops -> timeout_o = 1 exactly 102 cycles after the last event (TIMEOUT_CYCLES = 102), lock_o = 0. The next strobe clears timeout_o, no period is reported, and the following strobe 51 cycles later reports 51.
- strobe_i held high 5 cycles, then low, period 51 -> counted as single events, period_o = 51.
- Event coincident with clear_i mid-measurement -> all outputs return to reset values. The next two events, 51 cycles apart, report period_o = 51 once.
- With STROBE_MON_STATS_EN, periods 50, 53, 49 -> min_period_o = 49, max_period_o = 53. clear_i restores all-ones and 0.

Source files
------------

// File: rtl/strobe_period_monitor.sv
// strobe_period_monitor
// Measures the clock count between rising edges of a periodic strobe.
// Each measured period is checked against an expected rate and tolerance.
// Lock is declared after LOCK_COUNT consecutive in-tolerance periods.
// A timeout is flagged when strobes stop arriving.
//
// Optional build macro STROBE_MON_STATS_EN adds min/max period tracking.
// BOARD_CLK_MHZ (macro) is the board clock in MHz and defaults to 50.
//
// Ports:
//   clk_i          - system clock
//   rst_i          - synchronous active-high reset
//   strobe_i       - monitored strobe; a rising edge is one event
//   clear_i        - synchronous soft clear, same effect as rst_i
//   period_o       - last measured period in cycles
//   period_valid_o - one-cycle pulse when period_o updates
//   in_tol_o       - tolerance result of the last period
//   lock_o         - high after LOCK_COUNT consecutive in-tolerance periods
//   timeout_o      - high while no strobe has arrived for TIMEOUT_CYCLES
//   min_period_o   - smallest measured period (STROBE_MON_STATS_EN only)
//   max_period_o   - largest measured period  (STROBE_MON_STATS_EN only)

`ifndef BOARD_CLK_MHZ
`define BOARD_CLK_MHZ 32'd50
`endif

module strobe_period_monitor #(
  parameter int unsigned EXPECTED_FREQ_HZ = 32'd1,
  parameter int unsigned TOL_CYCLES       = 32'd2,
  parameter int unsigned LOCK_COUNT       = 32'd4,
  parameter int unsigned TIMEOUT_CYCLES   =
    32'd2 * ((32'(`BOARD_CLK_MHZ) * 32'd1_000_000) / EXPECTED_FREQ_HZ + 32'd1),
  localparam int unsigned EXP_PERIOD =
    (32'(`BOARD_CLK_MHZ) * 32'd1_000_000) / EXPECTED_FREQ_HZ + 32'd1,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1),
  localparam int LCK_W = $clog2(LOCK_COUNT + 32'd1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             strobe_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             in_tol_o,
  output logic             lock_o,
`ifdef STROBE_MON_STATS_EN
  output logic [CNT_W-1:0] min_period_o,
  output logic [CNT_W-1:0] max_period_o,
`endif
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] EXP_CNT     = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TO_CNT      = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [LCK_W-1:0] LOCK_STREAK = LCK_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  // Larger minus smaller, so the unsigned deviation never wraps.
  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  state_e             state_q, state_d;
  logic               strobe_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               period_valid_q, period_valid_d;
  logic               in_tol_q, in_tol_d;
  logic               lock_q, lock_d;
  logic               timeout_q, timeout_d;
  logic [LCK_W-1:0]   streak_q, streak_d;

  logic               event_s;
  logic               in_tol_s;
  logic               measured_s;
  logic [LCK_W-1:0]   streak_inc_s;

  assign event_s    = strobe_i & ~strobe_q;
  assign in_tol_s   = (32'(abs_diff(cnt_q, EXP_CNT)) <= TOL_CYCLES);
  assign measured_s = (state_q == ST_MEASURE) & event_s;
  // Streak saturates at LOCK_COUNT so it cannot wrap while locked.
  assign streak_inc_s = (streak_q >= LOCK_STREAK) ? LOCK_STREAK
                                                  : (streak_q + LCK_W'(1));

  // State register and all datapath flops; clear_i acts like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q        <= ST_IDLE;
      strobe_q       <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      in_tol_q       <= 1'b0;
      lock_q         <= 1'b0;
      timeout_q      <= 1'b0;
      streak_q       <= '0;
    end else begin
      state_q        <= state_d;
      strobe_q       <= strobe_i;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      in_tol_q       <= in_tol_d;
      lock_q         <= lock_d;
      timeout_q      <= timeout_d;
      streak_q       <= streak_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (event_s) state_d = ST_MEASURE;
        else         state_d = ST_IDLE;
      end
      ST_MEASURE: begin
        // An event on the timeout cycle wins and is measured normally.
        if (event_s)              state_d = ST_MEASURE;
        else if (cnt_q == TO_CNT) state_d = ST_TIMEOUT;
        else                      state_d = ST_MEASURE;
      end
      ST_TIMEOUT: begin
        if (event_s) state_d = ST_MEASURE;
        else         state_d = ST_TIMEOUT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter, period capture, tolerance, lock and timeout updates.
  always_comb begin
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    in_tol_d       = in_tol_q;
    lock_d         = lock_q;
    timeout_d      = timeout_q;
    streak_d       = streak_q;
    case (state_q)
      ST_IDLE: begin
        if (event_s) cnt_d = CNT_ONE;
        else         cnt_d = '0;
      end
      ST_MEASURE: begin
        if (event_s) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          in_tol_d       = in_tol_s;
          cnt_d          = CNT_ONE;
          if (in_tol_s) begin
            streak_d = streak_inc_s;
            lock_d   = (streak_inc_s == LOCK_STREAK);
          end else begin
            streak_d = '0;
            lock_d   = 1'b0;
          end
        end else if (cnt_q == TO_CNT) begin
          // Counter holds at the limit while timed out.
          timeout_d = 1'b1;
          lock_d    = 1'b0;
          streak_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_TIMEOUT: begin
        // The long gap is not a valid period; restart measurement only.
        if (event_s) begin
          timeout_d = 1'b0;
          cnt_d     = CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign period_o       = period_q;
  assign period_valid_o = period_valid_q;
  assign in_tol_o       = in_tol_q;
  assign lock_o         = lock_q;
  assign timeout_o      = timeout_q;

`ifdef STROBE_MON_STATS_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;

  // Track extremes of measured periods; timeout gaps never reach here.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (measured_s) begin
      if (cnt_q < min_q) min_d = cnt_q;
      else               min_d = min_q;
      if (cnt_q > max_q) max_d = cnt_q;
      else               max_d = max_q;
    end else begin
      min_d = min_q;
      max_d = max_q;
    end
  end

  // Min/max registers; min resets to all ones so the first period wins.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_period_o = min_q;
  assign max_period_o = max_q;
`endif

endmodule
